// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like bus between instruction fetch and the load/store path,
// one outstanding transaction at a time, data-first with a fetch starvation guard.
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, INST_WAIT, DATA_WAIT} state_t;

    state_t     state, state_nx;
    logic       lock_valid, lock_owner;
    logic [2:0] starve_cnt;
    logic       gnt_any, gnt_data, issue, accept, resp, starved;

    // Outputs are gated by rst so they read 0 the moment reset asserts.
    always_comb begin
        starved      = inst_req && starve_cnt == 3'(STARVE_LIMIT);
        gnt_any      = lock_valid || data_req || inst_req;
        gnt_data     = lock_valid ? lock_owner : data_req && !starved;
        issue        = rst && state == IDLE && gnt_any;
        accept       = issue && bus_addr_ok;
        resp         = rst && state != IDLE && bus_data_ok;
        bus_req      = issue;
        bus_wr       = issue && gnt_data && data_wr;
        bus_size     = !issue ? 2'd0 : gnt_data ? data_size : 2'd2;
        bus_addr     = !issue ? 32'd0 : gnt_data ? data_addr : inst_addr;
        bus_wdata    = issue && gnt_data ? data_wdata : 32'd0;
        inst_addr_ok = accept && !gnt_data;
        data_addr_ok = accept && gnt_data;
        inst_data_ok = resp && state == INST_WAIT;
        data_data_ok = resp && state == DATA_WAIT;
        inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
        data_rdata   = data_data_ok ? bus_rdata : 32'd0;
        state_nx     = state;
        if (accept)
            state_nx = gnt_data ? DATA_WAIT : INST_WAIT;
        else if (resp)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
            starve_cnt <= 3'd0;
        end else if (accept) begin
            lock_valid <= 1'b0;
            if (gnt_data && inst_req)
                starve_cnt <= starve_cnt == 3'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 3'd1;
            else
                starve_cnt <= 3'd0;
        end else if (issue) begin
            lock_valid <= 1'b1;
            lock_owner <= gnt_data;
        end
    end

    // A locked requester must keep its request up until the bus accepts it.
    req_held_while_locked: assert property (@(posedge clk) disable iff (!rst)
        (state == IDLE && lock_valid) |-> (lock_owner ? data_req : inst_req));
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed checks of grant order, lock, starvation guard, store fields and reset.
module tb_sram_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, data_wr;
    logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
    logic [1:0]  data_size;
    logic        bus_addr_ok, bus_data_ok;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    int          vectors = 0;
    int          miscompares = 0;

    sram_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; inputs set afterwards are settled 1ns later for checking.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hBFC00000;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h12345678;
        #2;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("rst_rdata", inst_rdata | data_rdata, 0);
        chk("rst_starve", dut.starve_cnt, 0);
        cyc();
        rst = 1'b1; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; inst_req = 1'b0;

        // Inst only: accept at cycle 0, response at cycle 3
        cyc(); inst_req = 1'b1; bus_addr_ok = 1'b1; #1;
        chk("i0_bus_req", bus_req, 1);
        chk("i0_bus_addr", bus_addr, 32'hBFC00000);
        chk("i0_bus_size", bus_size, 2);
        chk("i0_bus_wr", bus_wr, 0);
        chk("i0_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
        cyc(); inst_req = 1'b0; bus_addr_ok = 1'b0; #1;
        chk("i1_bus_req", bus_req, 0);
        cyc(); #1;
        chk("i2_bus_req", bus_req, 0);
        cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h3C1A0000; #1;
        chk("i3_bus_req", bus_req, 0);
        chk("i3_data_ok", {inst_data_ok, data_data_ok}, 2'b10);
        chk("i3_inst_rdata", inst_rdata, 32'h3C1A0000);
        chk("i3_data_rdata", data_rdata, 0);
        cyc(); bus_data_ok = 1'b0; #1;
        chk("i4_idle_data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("i4_inst_rdata", inst_rdata, 0);

        // Simultaneous requests: data wins, inst follows after the response
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00004;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80001000; bus_addr_ok = 1'b1; #1;
        chk("s0_bus_addr", bus_addr, 32'h80001000);
        chk("s0_bus_wr", bus_wr, 0);
        chk("s0_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
        cyc(); data_req = 1'b0; bus_addr_ok = 1'b0; #1;
        chk("s1_bus_req", bus_req, 0);
        chk("s1_starve", dut.starve_cnt, 1);
        cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h11223344; #1;
        chk("s2_bus_req", bus_req, 0);
        chk("s2_data_ok", {inst_data_ok, data_data_ok}, 2'b01);
        chk("s2_data_rdata", data_rdata, 32'h11223344);
        chk("s2_inst_rdata", inst_rdata, 0);
        cyc(); bus_data_ok = 1'b0; bus_addr_ok = 1'b1; #1;
        chk("s3_bus_addr", bus_addr, 32'hBFC00004);
        chk("s3_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
        cyc(); inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000ABCD; #1;
        chk("s4_inst_data_ok", inst_data_ok, 1);
        chk("s4_starve", dut.starve_cnt, 0);
        cyc(); bus_data_ok = 1'b0;

        // Lock on data, inst arrives while bus stalls
        cyc(); data_req = 1'b1; data_addr = 32'h80002000; #1;
        chk("l0_bus_addr", bus_addr, 32'h80002000);
        chk("l0_data_addr_ok", data_addr_ok, 0);
        cyc(); #1;
        cyc(); #1;
        chk("l2_bus_req", bus_req, 1);
        cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00008; #1;
        chk("l3_bus_addr", bus_addr, 32'h80002000);
        chk("l3_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        cyc(); bus_addr_ok = 1'b1; #1;
        chk("l4_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
        cyc(); data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h55AA55AA; #1;
        chk("l5_data_ok", data_data_ok, 1);
        // Lock on inst: a late data request must not steal the bus
        cyc(); bus_data_ok = 1'b0; #1;
        chk("l6_bus_addr", bus_addr, 32'hBFC00008);
        cyc(); data_req = 1'b1; data_addr = 32'h80003000; #1;
        chk("l7_bus_addr", bus_addr, 32'hBFC00008);
        cyc(); bus_addr_ok = 1'b1; #1;
        chk("l8_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
        cyc(); inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
        chk("l9_inst_data_ok", inst_data_ok, 1);
        cyc(); bus_data_ok = 1'b0; bus_addr_ok = 1'b1; #1;
        chk("l10_bus_addr", bus_addr, 32'h80003000);
        chk("l10_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
        cyc(); data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
        chk("l11_data_ok", data_data_ok, 1);
        cyc(); bus_data_ok = 1'b0;

        // Starvation guard: four data grants, then inst
        cyc(); data_req = 1'b1; data_addr = 32'h80004000; inst_req = 1'b1; inst_addr = 32'hBFC00010;
        for (int i = 0; i < 4; i++) begin
            bus_addr_ok = 1'b1; bus_data_ok = 1'b0; #1;
            chk("st_data_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
            cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
            chk("st_data_data_ok", data_data_ok, 1);
            chk("st_cnt", dut.starve_cnt, 32'(i + 1));
            cyc();
        end
        bus_addr_ok = 1'b1; bus_data_ok = 1'b0; #1;
        chk("st5_bus_addr", bus_addr, 32'hBFC00010);
        chk("st5_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
        cyc(); inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
        chk("st6_inst_data_ok", inst_data_ok, 1);
        chk("st6_cnt", dut.starve_cnt, 0);
        chk("st6_bus_req", bus_req, 0);
        cyc(); data_req = 1'b0; bus_data_ok = 1'b0;

        // Store byte
        cyc(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h80000003;
        data_wdata = 32'h000000AB; bus_addr_ok = 1'b1; #1;
        chk("sb_bus_wr", bus_wr, 1);
        chk("sb_bus_size", bus_size, 0);
        chk("sb_bus_addr", bus_addr, 32'h80000003);
        chk("sb_bus_wdata", bus_wdata, 32'h000000AB);
        cyc(); data_req = 1'b0; data_wr = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'd0; #1;
        chk("sb_data_ok", {inst_data_ok, data_data_ok}, 2'b01);
        cyc(); bus_data_ok = 1'b0;

        // Async reset in DATA_WAIT, then spurious responses in IDLE
        cyc(); data_req = 1'b1; data_size = 2'd2; data_addr = 32'h80005000; bus_addr_ok = 1'b1; #1;
        chk("ar_addr_ok", data_addr_ok, 1);
        cyc(); data_req = 1'b0; inst_req = 1'b1; bus_addr_ok = 1'b0; #1;
        bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF; rst = 1'b0; #1;
        chk("ar_data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("ar_data_rdata", data_rdata, 0);
        chk("ar_bus_req", bus_req, 0);
        cyc(); rst = 1'b1; inst_req = 1'b0; #1;
        chk("sp_data_ok", {inst_data_ok, data_data_ok}, 0);
        cyc(); bus_addr_ok = 1'b1; #1;
        chk("sp_bus_req", bus_req, 0);
        chk("sp_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        cyc(); bus_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC00020; #1;
        chk("sp_idle_grant", {bus_req, inst_addr_ok}, 2'b11);
        cyc(); inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0BADF00D; #1;
        chk("sp_inst_rdata", inst_rdata, 32'h0BADF00D);
        cyc(); bus_data_ok = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Arbitrates the CPU's single sram-like external bus between instruction fetch (inst port) and the MEM-stage load/store path (data port).
- Sits between the pipeline front end / MEM stage and the bus bridge.
- Sequences one outstanding transaction at a time. Data has fixed priority, bounded by a starvation guard for fetch.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while inst_req is pending before inst is forced to win.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request; held with inst_addr stable until inst_addr_ok
- inst_addr  in  32  fetch address (always read, size 2'b10)
- inst_addr_ok  out  1  fetch request accepted by bus
- inst_data_ok  out  1  fetch data returned
- inst_rdata  out  32  fetch data, valid with inst_data_ok
- data_req  in  1  load/store request; held with fields stable until data_addr_ok
- data_wr  in  1  1 = store
- data_size  in  2  0 byte, 1 half, 2 word
- data_addr  in  32  load/store address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data returned / store completed
- data_rdata  out  32  load data, valid with data_data_ok
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_size  out  2  bus size
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_addr_ok  in  1  bus accepted request
- bus_data_ok  in  1  bus response
- bus_rdata  in  32  bus read data

Behaviour:
- FSM states:
  - IDLE: no transaction outstanding.
  - INST_WAIT: fetch accepted, awaiting response.
  - DATA_WAIT: load/store accepted, awaiting response.
- Registers:
  - lock_valid, lock_owner: grant held over an unaccepted request.
  - starve_cnt: 3 bits, saturating at STARVE_LIMIT.
- Reset (rst=0, asynchronous): state=IDLE, lock_valid=0, starve_cnt=0. All outputs 0, including bus_*, *_addr_ok, *_data_ok and *_rdata.
- Grant selection, IDLE only:
  - If lock_valid, grant = lock_owner.
  - Else if data_req and inst_req and starve_cnt==STARVE_LIMIT, grant inst.
  - Else if data_req, grant data.
  - Else if inst_req, grant inst.
  - Else no grant: bus_req=0.
- In IDLE with a grant:
  - bus_req=1. bus_wr/size/addr/wdata are driven combinationally from the granted port.
  - For inst: wr=0, size=2, wdata=0.
- Grant accepted (bus_addr_ok=1):
  - Pulse the owner's *_addr_ok in the same cycle, combinationally.
  - Clear lock_valid.
  - Next state is INST_WAIT or DATA_WAIT.
- Grant not accepted (bus_addr_ok=0): set lock_valid=1 and lock_owner=grant. The grant never switches while a request is pending on the bus.
- starve_cnt update, on each accepted grant:
  - Data accepted while inst_req=1: starve_cnt+1, saturating.
  - Inst accepted: starve_cnt=0.
  - Data accepted while inst_req=0: starve_cnt=0.
- In INST_WAIT / DATA_WAIT:
  - bus_req=0 and both *_addr_ok=0.
  - On bus_data_ok: pulse the owner's *_data_ok for one cycle, drive the owner's *_rdata = bus_rdata, and return to IDLE.
  - No new request is issued in the same cycle as bus_data_ok; next issue is at the earliest one cycle later.
- *_rdata: the non-owner's rdata is 0. Both are 0 outside a data_ok cycle.
- bus_data_ok in IDLE is spurious: ignore it. No data_ok pulse, no state change.
- bus_addr_ok while bus_req=0: ignore it.
- Requester drops req before addr_ok: protocol violation. The arbiter still holds the lock and drives the held fields from the live port inputs. Assert this in simulation.
- Reset mid-transaction: any in-flight response is dropped. The bus bridge is reset by the same rst.
- Latency:
  - Request to addr_ok: combinational with bus_addr_ok.
  - Response to data_ok: combinational with bus_data_ok.
  - Minimum 2 cycles between successive bus_req assertions.

Test Plan:
- Inst only: inst_req=1, inst_addr=0xBFC00000; bus accepts cycle 0, data_ok cycle 3 with rdata=0x3C1A0000 -> inst_addr_ok at cycle 0, inst_data_ok and inst_rdata=0x3C1A0000 at cycle 3; state returns to IDLE; bus_req=0 during cycles 1-3.
- Simultaneous inst_req and data_req (load word, 0x80001000), starve_cnt=0 -> bus_addr=0x80001000, bus_wr=0; data_addr_ok pulses; inst waits; inst granted in the first IDLE cycle after data_data_ok.
- Lock: data_req granted, bus_addr_ok=0 for 3 cycles, then inst_req rises with data_req still high -> bus fields stay on data; data_addr_ok only when bus_addr_ok=1; inst never shown on bus in between.
- Starvation: data_req and inst_req held high, each bus transaction 1-cycle accept + 1-cycle response -> 4 data grants with starve_cnt counting 1..4, 5th grant goes to inst, starve_cnt=0 after it.
- Store byte: data_wr=1, size=0, addr=0x80000003, wdata=0x000000AB -> bus_wr=1, bus_size=0, bus_wdata=0x000000AB; data_data_ok on bus response; inst_data_ok stays 0.
- Async reset in DATA_WAIT, plus spurious data_ok: assert rst=0 mid-cycle -> all outputs 0 immediately; after release, a bus_data_ok in IDLE produces no data_ok pulse and state stays IDLE.
